// File: rtl/uart_tx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : Free-running 8N1 UART transmitter. It sends the byte on
//               `data` continuously, sampling it once at each frame start.
//               Define UART_TX_PARITY_EN to add an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
    parameter int BAUD = 115200,
    parameter int F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       tx
);

    localparam int CLKS_PER_BIT = F / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_rate_check
        $error("uart_tx_core: F/BAUD must be at least 2");
    end

`ifdef UART_TX_PARITY_EN
    localparam int ST_W = 3;
    localparam logic [2:0] IDLE   = 3'b011;
    localparam logic [2:0] START  = 3'b000;
    localparam logic [2:0] DATA   = 3'b001;
    localparam logic [2:0] STOP   = 3'b010;
    localparam logic [2:0] PARITY = 3'b100;
`else
    localparam int ST_W = 2;
    localparam logic [1:0] IDLE   = 2'b11;
    localparam logic [1:0] START  = 2'b00;
    localparam logic [1:0] DATA   = 2'b01;
    localparam logic [1:0] STOP   = 2'b10;
`endif

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             hold_q;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign tx      = tx_q;

    // hold_q swallows the first edge after reset so the opening IDLE period
    // spans a full CLKS_PER_BIT clocks measured from reset release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        if (hold_q) begin
            cnt_d = '0;
        end else if (bit_end) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    state_d = START;
                    shreg_d = data;
                end
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
                DATA: begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY:  state_d = STOP;
`endif
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = ^shreg_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            hold_q  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_core
// Description : Self-checking bench for uart_tx_core with a cycle-level
//               waveform model derived from the frame layout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

    localparam int F_HZ   = 1000;
    localparam int BAUD_R = 100;
    localparam int N      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL    = 11 + PAR;
    localparam int FRAME = FL * N;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] data = 8'h00;
    logic       tx;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = -1;
    logic [7:0] mbyte  = 8'h00;

    always #5 clk = ~clk;

    uart_tx_core #(.BAUD(BAUD_R), .F(F_HZ)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .tx   (tx)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq;   // expected line levels, first transmitted bit on the left
        logic       par;
    } vec_t;

    vec_t vecs[6];

    // Expected line level k edges after reset release; b is the byte of the current frame.
    function automatic logic model_tx(input int k, input logic [7:0] b);
        int p;
        int slot;
        if (k < N) return 1'b1;
        p    = (k - N) % FRAME;
        slot = p / N;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PAR == 1 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cyc=%0d tx=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        logic       r;
        logic [7:0] d;
        r = rst;
        d = data;
        @(posedge clk);
        #1;
        if (r) begin
            cyc = -1;
        end else begin
            cyc++;
            if (cyc >= N && (cyc - N) % FRAME == 0) mbyte = d;
        end
        chk("model", tx, model_tx(cyc, mbyte));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        steps(n);
        rst = 1'b0;
    endtask

    // Length of the run of equal tx levels starting at the current cycle.
    task automatic measure_run(output int len);
        logic v;
        v   = tx;
        len = 1;
        for (int i = 0; i < 20 * N; i++) begin
            step();
            if (tx !== v) break;
            len++;
        end
    endtask

    initial begin
        int len;
        int lows_start[$];
        int lows_len[$];
        int run;
        logic prev;

        vecs[0] = '{8'hD3, 8'b11001011, 1'b1};
        vecs[1] = '{8'h2C, 8'b00110100, 1'b1};
        vecs[2] = '{8'hFF, 8'b11111111, 1'b0};
        vecs[3] = '{8'h00, 8'b00000000, 1'b0};
        vecs[4] = '{8'hA5, 8'b10100101, 1'b0};
        vecs[5] = '{8'h01, 8'b10000000, 1'b1};

        // Table: one frame per vector, sampled mid-bit.
        for (int v = 0; v < 6; v++) begin
            data = vecs[v].din;
            do_reset(3);
            chk("reset_tx", tx, 1'b1);
            step_to(N / 2);
            chk("idle", tx, 1'b1);
            step_to(N + N / 2);
            chk("start", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                step_to((2 + i) * N + N / 2);
                chk("data_bit", tx, vecs[v].seq[7-i]);
            end
            if (PAR == 1) begin
                step_to(10 * N + N / 2);
                chk("parity", tx, vecs[v].par);
            end
            step_to((10 + PAR) * N + N / 2);
            chk("stop", tx, 1'b1);
        end

        // Exact state durations, using a byte that toggles every bit.
        data = 8'h55;
        do_reset(2);
        step();
        measure_run(len); chk_int("idle_len", len, N);
        measure_run(len); chk_int("start_len", len, N);
        measure_run(len); chk_int("bit0_len", len, N);
        measure_run(len); chk_int("bit1_len", len, N);

        // Data changed mid-frame is only picked up by the following frame.
        data = 8'hD3;
        do_reset(2);
        step_to(5 * N + 2);
        data = 8'h2C;
        step_to(8 * N + N / 2);
        chk("old_bit6", tx, vecs[0].seq[1]);
        step_to(9 * N + N / 2);
        chk("old_bit7", tx, vecs[0].seq[0]);
        for (int i = 0; i < 8; i++) begin
            step_to(FRAME + (2 + i) * N + N / 2);
            chk("new_bit", tx, vecs[1].seq[7-i]);
        end

        // One-clock reset during data bit 4 aborts the frame.
        data = 8'hA5;
        do_reset(2);
        step_to(6 * N + N / 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_tx", tx, 1'b1);
        measure_run(len);
        chk_int("abort_idle_len", len, N + 1);
        chk("abort_start", tx, 1'b0);

`ifndef UART_TX_PARITY_EN
        // Constant 0xFF: only start bits go low, one per frame.
        data = 8'hFF;
        do_reset(2);
        prev = 1'b1;
        run  = 0;
        for (int i = 0; i < 3 * FRAME + N; i++) begin
            step();
            if (tx === 1'b0) begin
                if (prev === 1'b1) lows_start.push_back(cyc);
                run++;
            end else if (prev === 1'b0) begin
                lows_len.push_back(run);
                run = 0;
            end
            prev = tx;
        end
        chk_int("ff_low_count", lows_start.size(), 3);
        chk_int("ff_len_count", lows_len.size(), 3);
        for (int i = 0; i < lows_len.size(); i++) chk_int("ff_low_len", lows_len[i], N);
        for (int i = 1; i < lows_start.size(); i++)
            chk_int("ff_spacing", lows_start[i] - lows_start[i-1], FRAME);
`endif

        // Random data changes and occasional resets against the model.
        data = 8'($urandom);
        do_reset(int'($urandom_range(1, 4)));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 36) == 0) data = 8'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
